// File: rtl/auth_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : auth_sched_pkg
// Purpose  : Shared types, constants and step functions for the shared
//            authentication engine scheduler. The step functions define the
//            PUF and hash192 arithmetic for both the RTL and its reference.
// Contents : op_e, status_e, state_e enums; HASH_IV/HASH_RK constants;
//            PUF_STEPS/HASH_ROUNDS; lfsr_step(); hash_round().
// Revision : 1.0 - initial release
// ============================================================================
package auth_sched_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_PUF  = 2'b01,
    OP_HASH = 2'b10,
    OP_BAD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK    = 2'b00,
    ST_STALE = 2'b01,
    ST_BADOP = 2'b10
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [63:0] HASH_IV     = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] HASH_RK     = 64'hC3C3_C3C3_C3C3_C3C3;
  localparam int          PUF_STEPS   = 64;
  localparam int          HASH_ROUNDS = 4;

  // One PUF LFSR step: shift left, feedback taps 63/62/60/59 into bit 0.
  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  // One hash192 round i: mixes 64-bit chunk i of data and a shifted round key.
  function automatic logic [63:0] hash_round(input logic [63:0]  s,
                                             input logic [255:0] data,
                                             input logic [1:0]   i);
    logic [63:0] chunk;
    logic [63:0] rk;
    chunk = data[{i, 6'd0} +: 64];
    rk    = HASH_RK >> ({4'd0, i} * 6'd9);
    return (s ^ chunk) ^ ((s << 3) ^ (s >> 5)) ^ rk;
  endfunction

endpackage
`default_nettype wire

// File: rtl/crypto_iter_engine.sv
`default_nettype none
// ============================================================================
// Module   : crypto_iter_engine
// Purpose  : Iterative PUF / hash192 engine, one step per clock.
// Ports    : clk, rst_n     - clock, async active-low reset
//            start_i        - load initial state and begin stepping
//            op_i [1:0]     - OP_HASH selects hash, anything else runs PUF
//            data_i [255:0] - operand, must stay stable while running
//            done_o         - high during the cycle of the final step
//            result_o[63:0] - value after the current step (valid with done_o)
// Revision : 1.0 - initial release
// ============================================================================
module crypto_iter_engine
  import auth_sched_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [1:0]   op_i,
  input  logic [255:0] data_i,
  output logic         done_o,
  output logic [63:0]  result_o
);

  logic        run_q, run_d;
  logic        hash_q, hash_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] s_q, s_d;
  logic [63:0] w_step;
  logic [5:0]  w_last;

  assign w_step   = hash_q ? hash_round(s_q, data_i, cnt_q[1:0]) : lfsr_step(s_q);
  assign w_last   = hash_q ? 6'(HASH_ROUNDS - 1) : 6'(PUF_STEPS - 1);
  // Result is taken combinationally so the owner can leave RUN on the same
  // edge that applies the last step.
  assign done_o   = run_q && (cnt_q == w_last);
  assign result_o = w_step;

  always_comb begin
    run_d  = run_q;
    hash_d = hash_q;
    cnt_d  = cnt_q;
    s_d    = s_q;
    if (start_i) begin
      run_d  = 1'b1;
      hash_d = (op_i == OP_HASH);
      cnt_d  = '0;
      s_d    = (op_i == OP_HASH) ? HASH_IV : data_i[63:0];
    end else if (run_q) begin
      s_d = w_step;
      if (done_o) begin
        run_d = 1'b0;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      hash_q <= 1'b0;
      cnt_q  <= '0;
      s_q    <= '0;
    end else begin
      run_q  <= run_d;
      hash_q <= hash_d;
      cnt_q  <= cnt_d;
      s_q    <= s_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/auth_engine_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : auth_engine_scheduler
// Purpose  : Shares one iterative PUF/hash engine among NUM_REQ requesters
//            with round-robin arbitration and timestamp freshness checking.
// Ports    : clk, rst_n            - clock, async active-low reset
//            req_valid/req_ready   - per-requester handshake (ready one-hot)
//            req_op/req_data/req_ts- per-requester op, operand, timestamp
//            now_ts                - free-running 64-bit cycle counter
//            rsp_valid/rsp_ready   - response handshake
//            rsp_id/data/status    - tagged result (data 0 unless OK)
//            busy                  - scheduler not idle
//            cnt_ok/cnt_rej        - saturating response statistics
// Revision : 1.0 - initial release
// ============================================================================
module auth_engine_scheduler
  import auth_sched_pkg::*;
#(
  parameter int  NUM_REQ          = 4,
  parameter int  ACCEPTABLE_DELAY = 10,
  parameter int  CNT_W            = 16,
  localparam int IDW              = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [256*NUM_REQ-1:0]   req_data,
  input  logic [64*NUM_REQ-1:0]    req_ts,
  output logic [63:0]              now_ts,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [63:0]              rsp_data,
  output logic [1:0]               rsp_status,
  output logic                     busy,
  output logic [CNT_W-1:0]         cnt_ok,
  output logic [CNT_W-1:0]         cnt_rej
);

  state_e             state_q, state_d;
  logic [IDW-1:0]     rr_q, rr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [1:0]         op_q, op_d;
  logic [255:0]       data_q, data_d;
  logic [63:0]        ts_q, ts_d;
  logic [63:0]        now_q;
  logic [63:0]        rsp_data_q, rsp_data_d;
  logic [1:0]         status_q, status_d;
  logic [CNT_W-1:0]   cnt_ok_q, cnt_ok_d;
  logic [CNT_W-1:0]   cnt_rej_q, cnt_rej_d;

  logic [1:0]         w_op   [NUM_REQ];
  logic [255:0]       w_data [NUM_REQ];
  logic [63:0]        w_ts   [NUM_REQ];
  logic               w_any;
  logic [IDW-1:0]     w_grant;
  logic [IDW:0]       w_idx;
  logic [63:0]        w_age;
  logic               w_eng_start;
  logic               w_eng_done;
  logic [63:0]        w_eng_result;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_op[g]   = req_op[2*g +: 2];
    assign w_data[g] = req_data[256*g +: 256];
    assign w_ts[g]   = req_ts[64*g +: 64];
  end

  // Circular search starting at rr_q; the first valid requester wins.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, rr_q} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(NUM_REQ)) begin
        w_idx = w_idx - (IDW+1)'(NUM_REQ);
      end
      if (!w_any && req_valid[w_idx[IDW-1:0]]) begin
        w_any   = 1'b1;
        w_grant = w_idx[IDW-1:0];
      end
    end
  end

  // Unsigned subtraction makes a future timestamp look very old.
  assign w_age = now_q - ts_q;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    id_d        = id_q;
    op_d        = op_q;
    data_d      = data_q;
    ts_d        = ts_q;
    rsp_data_d  = rsp_data_q;
    status_d    = status_q;
    cnt_ok_d    = cnt_ok_q;
    cnt_rej_d   = cnt_rej_q;
    w_eng_start = 1'b0;
    req_ready   = '0;
    case (state_q)
      S_IDLE: begin
        if (w_any) begin
          req_ready[w_grant] = 1'b1;
          id_d    = w_grant;
          op_d    = w_op[w_grant];
          data_d  = w_data[w_grant];
          ts_d    = w_ts[w_grant];
          rr_d    = (w_grant == IDW'(NUM_REQ - 1)) ? '0 : w_grant + IDW'(1);
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (op_q != OP_PUF && op_q != OP_HASH) begin
          status_d   = ST_BADOP;
          rsp_data_d = '0;
          state_d    = S_DONE;
        end else if (w_age > 64'(ACCEPTABLE_DELAY)) begin
          status_d   = ST_STALE;
          rsp_data_d = '0;
          state_d    = S_DONE;
        end else begin
          w_eng_start = 1'b1;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        if (w_eng_done) begin
          rsp_data_d = w_eng_result;
          status_d   = ST_OK;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          if (status_q == ST_OK) begin
            if (cnt_ok_q != '1) cnt_ok_d = cnt_ok_q + CNT_W'(1);
          end else begin
            if (cnt_rej_q != '1) cnt_rej_d = cnt_rej_q + CNT_W'(1);
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      id_q       <= '0;
      op_q       <= '0;
      data_q     <= '0;
      ts_q       <= '0;
      now_q      <= '0;
      rsp_data_q <= '0;
      status_q   <= '0;
      cnt_ok_q   <= '0;
      cnt_rej_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      id_q       <= id_d;
      op_q       <= op_d;
      data_q     <= data_d;
      ts_q       <= ts_d;
      now_q      <= now_q + 64'd1;
      rsp_data_q <= rsp_data_d;
      status_q   <= status_d;
      cnt_ok_q   <= cnt_ok_d;
      cnt_rej_q  <= cnt_rej_d;
    end
  end

  crypto_iter_engine u_engine (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (w_eng_start),
    .op_i     (op_q),
    .data_i   (data_q),
    .done_o   (w_eng_done),
    .result_o (w_eng_result)
  );

  assign now_ts     = now_q;
  assign rsp_valid  = (state_q == S_DONE);
  assign rsp_id     = id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_status = status_q;
  assign busy       = (state_q != S_IDLE);
  assign cnt_ok     = cnt_ok_q;
  assign cnt_rej    = cnt_rej_q;

endmodule
`default_nettype wire
